ivar_counter: RTL

Single-dimension iteration-variable generator for the Global Controller. Steps a signed iteration variable from a lower to an upper bound by a signed stride. Produces the `ivar` value that the min/max comparators test against their ranges. Instances chain through `tick_in`/`carry_out` to form a multi-dimensional loop nest, with the innermost dimension clocked by the schedule tick.

---
 rtl/ivar_counter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ivar_counter.sv
// Signed iteration-variable generator for one loop dimension; chains via tick_in/carry_out.
// Optional stride-overflow detection is compiled in with IVAR_COUNTER_OVF_CHECK_EN.
module ivar_counter #(
  parameter int unsigned ITERATION_VARIABLE_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_load,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] cfg_lb,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] cfg_ub,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] cfg_step,
  input  logic                                start,
  input  logic                                tick_in,
  input  logic                                outer_last,
  output logic [ITERATION_VARIABLE_WIDTH-1:0] ivar,
  output logic                                carry_out,
  output logic                                busy,
  output logic                                done,
  output logic                                ovf_err
);

  localparam int unsigned W = ITERATION_VARIABLE_WIDTH;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   ivar_q, ivar_d;
  logic [W-1:0]   lb_q, lb_d;
  logic [W-1:0]   ub_q, ub_d;
  logic [W-1:0]   step_q, step_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [W-1:0]   next_val;
  logic           step_zero, step_neg, step_pos;
  logic           wrap;

`ifdef IVAR_COUNTER_OVF_CHECK_EN
  logic           ovf_q, ovf_d;
  logic           ovf;

  // Same-sign operands producing a result of the other sign: bit W != bit W-1 of the wide sum.
  assign ovf = (ivar_q[W-1] == step_q[W-1]) && (next_val[W-1] != ivar_q[W-1]);
`endif

  assign next_val  = ivar_q + step_q;
  assign step_zero = (step_q == '0);
  assign step_neg  = step_q[W-1];
  assign step_pos  = !step_neg && !step_zero;

  // Bound test uses the W-bit sum so an overflowed step reads as in range and is flagged.
  assign wrap = (step_pos && ($signed(next_val) > $signed(ub_q))) ||
                (step_neg && ($signed(next_val) < $signed(ub_q))) ||
                step_zero;

  assign carry_out = (state_q == StRun) && tick_in && wrap;

  always_comb begin
    state_d = state_q;
    ivar_d  = ivar_q;
    lb_d    = lb_q;
    ub_d    = ub_q;
    step_d  = step_q;
`ifdef IVAR_COUNTER_OVF_CHECK_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (cfg_load) begin
          lb_d   = cfg_lb;
          ub_d   = cfg_ub;
          step_d = cfg_step;
        end
        if (start) begin
          ivar_d  = cfg_load ? cfg_lb : lb_q;
          state_d = StRun;
`ifdef IVAR_COUNTER_OVF_CHECK_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      StRun: begin
        if (tick_in) begin
          if (wrap) begin
            if (outer_last) begin
              state_d = StDone;
            end else begin
              ivar_d = lb_q;
            end
          end else begin
`ifdef IVAR_COUNTER_OVF_CHECK_EN
            if (ovf) begin
              ovf_d   = 1'b1;
              state_d = StDone;
            end else begin
              ivar_d = next_val;
            end
`else
            ivar_d = next_val;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ivar_q  <= '0;
      lb_q    <= '0;
      ub_q    <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef IVAR_COUNTER_OVF_CHECK_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ivar_q  <= ivar_d;
      lb_q    <= lb_d;
      ub_q    <= ub_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef IVAR_COUNTER_OVF_CHECK_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ivar = ivar_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef IVAR_COUNTER_OVF_CHECK_EN
  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule
